// File: rtl/morse_keyer_if.sv
// Character stream between a source (UART, host register) and the Morse keyer.
//   in_valid : source offers in_char this cycle
//   in_char  : 8-bit ASCII character
//   in_ready : keyer can accept (FIFO not full)
// A character transfers on a rising edge where in_valid && in_ready.
interface morse_keyer_if;
  logic       in_valid;
  logic [7:0] in_char;
  logic       in_ready;

  modport master (output in_valid, output in_char, input in_ready);
  modport slave  (input in_valid, input in_char, output in_ready);
endinterface

// File: rtl/morse_keyer.sv
// Morse keyer: buffers ASCII characters in a small FIFO and plays each one
// out as a timed on/off key waveform (dot = 1 unit, dash = DASH_UNITS,
// symbol/character/word gaps as parameterised).
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   chr         : character stream (slave side of morse_keyer_if)
//   key_out     : 1 = carrier on (high exactly while in MARK)
//   sym_strobe  : one-cycle pulse on the first cycle of every mark
//   bad_char    : one-cycle pulse when an unsupported character is dequeued
//   busy        : state machine active or characters still buffered
//   fifo_count  : number of buffered characters
module morse_keyer #(
  parameter int CLKS_PER_UNIT  = 50000,
  parameter int DASH_UNITS     = 3,
  parameter int SYM_GAP_UNITS  = 1,
  parameter int CHAR_GAP_UNITS = 3,
  parameter int WORD_GAP_UNITS = 7,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  morse_keyer_if.slave                chr,
  output logic                        key_out,
  output logic                        sym_strobe,
  output logic                        bad_char,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = (CLKS_PER_UNIT > 1) ? $clog2(CLKS_PER_UNIT) : 1;
  localparam int M1    = (DASH_UNITS > SYM_GAP_UNITS) ? DASH_UNITS : SYM_GAP_UNITS;
  localparam int M2    = (M1 > CHAR_GAP_UNITS) ? M1 : CHAR_GAP_UNITS;
  localparam int MAX_U = (M2 > WORD_GAP_UNITS) ? M2 : WORD_GAP_UNITS;
  localparam int UW    = (MAX_U > 1) ? $clog2(MAX_U) : 1;

  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_UNIT - 1);
  localparam logic [UW-1:0] DASH_LAST = UW'(DASH_UNITS - 1);
  localparam logic [UW-1:0] SGAP_LAST = UW'(SYM_GAP_UNITS - 1);
  localparam logic [UW-1:0] CGAP_LAST = UW'(CHAR_GAP_UNITS - 1);
  localparam logic [UW-1:0] WGAP_LAST = UW'(WORD_GAP_UNITS - CHAR_GAP_UNITS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, MARK, SGAP, CGAP, WGAP} state_t;
  typedef enum logic [1:0] {K_SYM, K_SPACE, K_BAD} kind_t;
  // Pattern is LSB-aligned: first symbol sits at bit len-1, 1 = dash.
  typedef struct packed {
    kind_t      kind;
    logic [2:0] len;
    logic [4:0] pat;
  } code_t;

  function automatic code_t lookup(input logic [7:0] c);
    code_t      r;
    logic [7:0] u;
    r = '{kind: K_BAD, len: 3'd0, pat: 5'd0};
    // Fold lower case onto upper case.
    u = (c >= 8'h61 && c <= 8'h7a) ? c - 8'h20 : c;
    case (u)
      "A": r = '{K_SYM, 3'd2, 5'b00001};
      "B": r = '{K_SYM, 3'd4, 5'b01000};
      "C": r = '{K_SYM, 3'd4, 5'b01010};
      "D": r = '{K_SYM, 3'd3, 5'b00100};
      "E": r = '{K_SYM, 3'd1, 5'b00000};
      "F": r = '{K_SYM, 3'd4, 5'b00010};
      "G": r = '{K_SYM, 3'd3, 5'b00110};
      "H": r = '{K_SYM, 3'd4, 5'b00000};
      "I": r = '{K_SYM, 3'd2, 5'b00000};
      "J": r = '{K_SYM, 3'd4, 5'b00111};
      "K": r = '{K_SYM, 3'd3, 5'b00101};
      "L": r = '{K_SYM, 3'd4, 5'b00100};
      "M": r = '{K_SYM, 3'd2, 5'b00011};
      "N": r = '{K_SYM, 3'd2, 5'b00010};
      "O": r = '{K_SYM, 3'd3, 5'b00111};
      "P": r = '{K_SYM, 3'd4, 5'b00110};
      "Q": r = '{K_SYM, 3'd4, 5'b01101};
      "R": r = '{K_SYM, 3'd3, 5'b00010};
      "S": r = '{K_SYM, 3'd3, 5'b00000};
      "T": r = '{K_SYM, 3'd1, 5'b00001};
      "U": r = '{K_SYM, 3'd3, 5'b00001};
      "V": r = '{K_SYM, 3'd4, 5'b00001};
      "W": r = '{K_SYM, 3'd3, 5'b00011};
      "X": r = '{K_SYM, 3'd4, 5'b01001};
      "Y": r = '{K_SYM, 3'd4, 5'b01011};
      "Z": r = '{K_SYM, 3'd4, 5'b01100};
      "0": r = '{K_SYM, 3'd5, 5'b11111};
      "1": r = '{K_SYM, 3'd5, 5'b01111};
      "2": r = '{K_SYM, 3'd5, 5'b00111};
      "3": r = '{K_SYM, 3'd5, 5'b00011};
      "4": r = '{K_SYM, 3'd5, 5'b00001};
      "5": r = '{K_SYM, 3'd5, 5'b00000};
      "6": r = '{K_SYM, 3'd5, 5'b10000};
      "7": r = '{K_SYM, 3'd5, 5'b11000};
      "8": r = '{K_SYM, 3'd5, 5'b11100};
      "9": r = '{K_SYM, 3'd5, 5'b11110};
      " ": r = '{K_SPACE, 3'd0, 5'd0};
      default: r = '{K_BAD, 3'd0, 5'd0};
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------- FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;
  state_t        state;
  code_t         head;

  assign chr.in_ready = (count < DEPTH_C);
  assign push         = chr.in_valid && chr.in_ready;
  assign pop          = (state == LOAD);
  assign fifo_count   = count;
  assign head         = lookup(mem[rd_ptr]);

  // NOTE: the storage array has no reset; the pointers and count alone decide
  // what is valid, so clearing the data would only cost logic.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= chr.in_char;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------- key timing
  logic [4:0]    pat;
  logic [2:0]    idx;
  logic [CW-1:0] cyc_cnt;
  logic [UW-1:0] unit_cnt;
  logic [UW-1:0] unit_last;
  logic          timed, elem_done;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    unit_last = '0;
    timed     = 1'b1;
    case (state)
      MARK:    unit_last = pat[idx] ? DASH_LAST : '0;
      SGAP:    unit_last = SGAP_LAST;
      CGAP:    unit_last = CGAP_LAST;
      WGAP:    unit_last = WGAP_LAST;
      default: timed     = 1'b0;
    endcase
  end

  assign elem_done = timed && (cyc_cnt == CYC_LAST) && (unit_cnt == unit_last);
  assign busy      = (state != IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      key_out    <= 1'b0;
      sym_strobe <= 1'b0;
      bad_char   <= 1'b0;
      pat        <= '0;
      idx        <= '0;
      cyc_cnt    <= '0;
      unit_cnt   <= '0;
    end else begin
      sym_strobe <= 1'b0;
      bad_char   <= 1'b0;

      // Counters run only in timed states and clear when the element ends,
      // so every state is entered with both at zero.
      if (timed) begin
        if (elem_done) begin
          cyc_cnt  <= '0;
          unit_cnt <= '0;
        end else if (cyc_cnt == CYC_LAST) begin
          cyc_cnt  <= '0;
          unit_cnt <= unit_cnt + UW'(1);
        end else begin
          cyc_cnt  <= cyc_cnt + CW'(1);
        end
      end

      case (state)
        IDLE: if (count != '0) state <= LOAD;
        LOAD: begin
          case (head.kind)
            K_SYM: begin
              pat        <= head.pat;
              idx        <= head.len - 3'd1;
              state      <= MARK;
              key_out    <= 1'b1;
              sym_strobe <= 1'b1;
            end
            // The preceding character gap already supplied CHAR_GAP_UNITS.
            K_SPACE: state <= (WORD_GAP_UNITS == CHAR_GAP_UNITS) ? IDLE : WGAP;
            default: begin
              bad_char <= 1'b1;
              state    <= IDLE;
            end
          endcase
        end
        MARK: if (elem_done) begin
          key_out <= 1'b0;
          if (idx != 3'd0) begin
            idx   <= idx - 3'd1;
            state <= SGAP;
          end else begin
            state <= CGAP;
          end
        end
        SGAP: if (elem_done) begin
          state      <= MARK;
          key_out    <= 1'b1;
          sym_strobe <= 1'b1;
        end
        CGAP:    if (elem_done) state <= IDLE;
        WGAP:    if (elem_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_keyer.sv
// Self-checking bench for morse_keyer with CLKS_PER_UNIT=2, other defaults.
// Accepted characters push their expected marks into a scoreboard; a monitor
// measures every mark on key_out (and the gap after non-final symbols) and
// compares against the popped entry. Directed checks cover latency, gaps,
// FIFO back-pressure, bad characters and mid-operation reset.
module tb_morse_keyer;
  localparam int CPU   = 2;
  localparam int DASH  = 3;
  localparam int SYM   = 1;
  localparam int CHR   = 3;
  localparam int WORD  = 7;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_out, sym_strobe, bad_char, busy;
  logic [2:0] fifo_count;

  morse_keyer_if chr_if ();

  morse_keyer #(
    .CLKS_PER_UNIT (CPU),
    .DASH_UNITS    (DASH),
    .SYM_GAP_UNITS (SYM),
    .CHAR_GAP_UNITS(CHR),
    .WORD_GAP_UNITS(WORD),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .chr       (chr_if),
    .key_out   (key_out),
    .sym_strobe(sym_strobe),
    .bad_char  (bad_char),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference code table written as dot/dash strings.
  function automatic string code_of(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= "a" && c <= "z") ? c - 8'd32 : c;
    case (u)
      "A": return ".-";    "B": return "-...";  "C": return "-.-.";  "D": return "-..";
      "E": return ".";     "F": return "..-.";  "G": return "--.";   "H": return "....";
      "I": return "..";    "J": return ".---";  "K": return "-.-";   "L": return ".-..";
      "M": return "--";    "N": return "-.";    "O": return "---";   "P": return ".--.";
      "Q": return "--.-";  "R": return ".-.";   "S": return "...";   "T": return "-";
      "U": return "..-";   "V": return "...-";  "W": return ".--";   "X": return "-..-";
      "Y": return "-.--";  "Z": return "--..";
      "0": return "-----"; "1": return ".----"; "2": return "..---"; "3": return "...--";
      "4": return "....-"; "5": return "....."; "6": return "-...."; "7": return "--...";
      "8": return "---.."; "9": return "----.";
      default: return "";
    endcase
  endfunction

  function automatic int n_marks(input string s);
    int t = 0;
    for (int i = 0; i < s.len(); i++) t += code_of(s[i]).len();
    return t;
  endfunction

  typedef struct {
    int mark;   // expected mark length in cycles
    int gap;    // expected following gap, -1 after a character's last symbol
  } sb_entry_t;

  sb_entry_t sb[$];

  // Scoreboard producer: every accepted character pushes its expected marks.
  always @(posedge clk) begin : producer
    string     s;
    sb_entry_t e;
    if (rst_n && chr_if.in_valid === 1'b1 && chr_if.in_ready === 1'b1) begin
      s = code_of(chr_if.in_char);
      for (int i = 0; i < s.len(); i++) begin
        e.mark = (s[i] == "-") ? DASH * CPU : CPU;
        e.gap  = (i == s.len() - 1) ? -1 : SYM * CPU;
        sb.push_back(e);
      end
    end
  end

  // Monitor: measure key_out runs away from the active edge.
  logic prev_key = 1'b0;
  int   hi = 0, lo = 0, pend_gap = -1;
  int   n_strobe = 0, n_bad = 0;
  int   low_runs[$];

  always @(negedge clk) begin : monitor
    sb_entry_t e;
    if (!rst_n) begin
      prev_key = 1'b0;
      hi       = 0;
      lo       = 0;
      pend_gap = -1;
      sb.delete();
    end else begin
      if (sym_strobe === 1'b1) n_strobe++;
      if (bad_char === 1'b1) n_bad++;
      if (key_out === 1'b1 && !prev_key) begin
        check("strobe_on_rise", sym_strobe, 1);
        low_runs.push_back(lo);
        if (pend_gap >= 0) check("sym_gap", lo, pend_gap);
        hi = 1;
      end else if (key_out === 1'b1) begin
        hi++;
      end else if (prev_key) begin
        if (sb.size() == 0) begin
          check("unexpected_mark", hi, 0);
          pend_gap = -1;
        end else begin
          e = sb.pop_front();
          check("mark_len", hi, e.mark);
          pend_gap = e.gap;
        end
        lo = 1;
      end else begin
        lo++;
      end
      prev_key = (key_out === 1'b1);
    end
  end

  // Offer a character from the next negedge; returns at the accepting edge.
  task automatic send(input logic [7:0] c);
    int budget = 500;
    @(negedge clk);
    chr_if.in_valid = 1'b1;
    chr_if.in_char  = c;
    while (chr_if.in_ready !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check("ready_timeout", 0, 1);
    @(posedge clk);
  endtask

  task automatic drop_valid();
    @(negedge clk);
    chr_if.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, busy, 0);
    check({tag, "_key_low"}, key_out, 0);
  endtask

  task automatic run_str(input string tag, input string s);
    int s0 = n_strobe;
    for (int i = 0; i < s.len(); i++) send(s[i]);
    drop_valid();
    wait_idle(tag);
    check({tag, "_strobes"}, n_strobe - s0, n_marks(s));
  endtask

  initial begin
    int    t, s0, b0, idx, cyc;
    logic  saw_full, stalled;
    string chars;

    chr_if.in_valid = 1'b0;
    chr_if.in_char  = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_key", key_out, 0);
    check("rst_strobe", sym_strobe, 0);
    check("rst_bad", bad_char, 0);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ready", chr_if.in_ready, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // "E": latency, single dot, CGAP tail then busy drops
    s0 = n_strobe;
    send("E");
    drop_valid();
    check("e_lat_k", key_out, 0);
    check("e_busy", busy, 1);
    check("e_count", fifo_count, 1);
    @(negedge clk);
    check("e_lat_k1", key_out, 0);
    @(negedge clk);
    check("e_lat_k2", key_out, 1);
    t = 0;
    while (key_out === 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    t = 0;
    while (busy === 1'b1 && t < 100) begin
      t++;
      @(negedge clk);
    end
    check("e_tail", t, CHR * CPU);
    wait_idle("e");
    check("e_strobes", n_strobe - s0, 1);

    // Case-insensitive letters and digits
    run_str("a_lower", "a");
    run_str("a_upper", "A");
    run_str("digit0", "0");
    run_str("digit5", "5");

    // Word gap: "S S"
    low_runs.delete();
    run_str("s_sp_s", "S S");
    check("s_sp_s_runs", low_runs.size(), 6);
    check("s_sp_s_gap", (low_runs.size() > 3) ? low_runs[3] : -1,
          CHR * CPU + 2 + (WORD - CHR) * CPU + 2);

    // FIFO back-pressure: hold in_valid across a burst larger than the FIFO
    chars    = "TESTON";
    idx      = 0;
    cyc      = 0;
    saw_full = 1'b0;
    stalled  = 1'b0;
    s0       = n_strobe;
    @(negedge clk);
    chr_if.in_valid = 1'b1;
    chr_if.in_char  = chars[0];
    while (idx < chars.len() && cyc < 500) begin
      if (fifo_count == 3'(DEPTH)) saw_full = 1'b1;
      if (chr_if.in_ready !== 1'b1) stalled = 1'b1;
      t = (chr_if.in_ready === 1'b1) ? 1 : 0;
      @(posedge clk);
      if (t == 1) idx++;
      @(negedge clk);
      cyc++;
      if (idx < chars.len()) chr_if.in_char = chars[idx];
      else chr_if.in_valid = 1'b0;
    end
    check("fifo_all_sent", idx, chars.len());
    check("fifo_full_seen", saw_full, 1);
    check("fifo_stall_seen", stalled, 1);
    wait_idle("fifo");
    check("fifo_strobes", n_strobe - s0, n_marks(chars));

    // Unsupported character between two letters
    b0 = n_bad;
    run_str("bad", "E#E");
    check("bad_pulses", n_bad - b0, 1);

    // Reset in the middle of a dash with characters still buffered
    send("T");
    send("T");
    send("T");
    drop_valid();
    t = 0;
    while (key_out !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("rst_mid_key_seen", key_out, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_key", key_out, 0);
    check("rst_mid_count", fifo_count, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ready", chr_if.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_str("after_rst", "N");

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
